// File: rtl/data_mem_responder.sv
// Data-port responder for the single-cycle CPU: services load/store requests from a
// word-addressed synchronous RAM or a memory-mapped LED register, with configurable latency.
module data_mem_responder #(
  parameter int          ADDR_W      = 10,
  parameter int          DATA_W      = 32,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] LED_ADDR    = 32'hFFFF_FF00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [7:0]        led_out
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, state_next;
  logic [3:0]        wait_cnt, wait_cnt_next;
  logic              live;
  logic              accept;
  logic              lat_write;
  logic [31:0]       lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              hit_ram, hit_led, dec_err;
  logic              ram_commit;
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

  // live holds req_ready low until the first clock after reset is released
  assign req_ready  = live && (state == IDLE);
  assign accept     = req_valid && req_ready;
  assign rsp_valid  = (state == RESP);
  assign rsp_err    = rsp_valid && dec_err;
  assign ram_commit = rsp_valid && lat_write && hit_ram;

  always_comb begin
    hit_ram = 1'b0;
    hit_led = 1'b0;
    dec_err = 1'b0;
    if (lat_addr[1:0] != 2'b00)
      dec_err = 1'b1;
    else if (lat_addr == LED_ADDR)
      hit_led = 1'b1;
    else if (lat_addr[31:ADDR_W+2] == '0)
      hit_ram = 1'b1;
    else
      dec_err = 1'b1;
  end

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES > 0) begin
            state_next    = WAIT;
            wait_cnt_next = 4'(WAIT_CYCLES - 1);
          end else begin
            state_next = RESP;
          end
        end
      end
      WAIT: begin
        if (wait_cnt == '0)
          state_next = RESP;
        else
          wait_cnt_next = wait_cnt - 4'd1;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      live      <= 1'b0;
      led_out   <= 8'h00;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      live     <= 1'b1;
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (accept) begin
        lat_write <= req_write;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
      end
      if (rsp_valid && lat_write && hit_led)
        led_out <= lat_wdata[7:0];
    end
  end

  // Read is captured at acceptance so the data is ready even with zero wait states;
  // a store commits at the edge leaving RESP, before any later acceptance can read it
  always_ff @(posedge clk) begin
    if (accept)
      ram_q <= mem[req_addr[ADDR_W+1:2]];
    if (ram_commit)
      mem[lat_addr[ADDR_W+1:2]] <= lat_wdata;
  end

  always_comb begin
    rsp_rdata = '0;
    if (rsp_valid && !lat_write && !dec_err)
      rsp_rdata = hit_led ? {{(DATA_W-8){1'b0}}, led_out} : ram_q;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: three responders (0, 1 and 3 wait states) driven by directed and
// random transactions, checked against an address-decode and memory model kept here.
module tb_data_mem_responder;

  localparam logic [31:0] LED = 32'hFFFF_FF00;

  logic        clk;
  logic        rst;
  logic        req_valid [3];
  logic        req_write [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic        req_ready [3];
  logic        rsp_valid [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];
  logic [7:0]  led_out   [3];

  int          errors = 0;
  int          checks = 0;
  logic [31:0] mdl_mem [int];
  logic [7:0]  mdl_led [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_mem_responder #(
      .WAIT_CYCLES(g == 0 ? 1 : (g == 1 ? 0 : 3))
    ) dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid[g]),
      .req_write(req_write[g]),
      .req_addr (req_addr[g]),
      .req_wdata(req_wdata[g]),
      .req_ready(req_ready[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_rdata(rsp_rdata[g]),
      .rsp_err  (rsp_err[g]),
      .led_out  (led_out[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int waits_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction on instance k, starting and ending at a falling edge with the DUT idle
  task automatic applyStimulus(input int k, input logic w, input logic [31:0] a, input logic [31:0] d);
    int          lat, n, key;
    logic        exp_e, rdy_bad, known;
    logic [31:0] exp_d;
    exp_e = (a[1:0] != 2'b00) || (a != LED && a >= 32'h0000_1000);
    key   = k * 1024 + int'(a[11:2]);
    exp_d = '0;
    known = 1'b1;
    if (!w && !exp_e) begin
      if (a == LED) exp_d = {24'h0, mdl_led[k]};
      else if (mdl_mem.exists(key)) exp_d = mdl_mem[key];
      else known = 1'b0;
    end
    req_valid[k] = 1'b1;
    req_write[k] = w;
    req_addr[k]  = a;
    req_wdata[k] = d;
    n = 0;
    while (!req_ready[k] && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    lat = 0;
    rdy_bad = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (req_ready[k]) rdy_bad = 1'b1;
      if (lat == 1) begin
        req_valid[k] = 1'b0;
        req_write[k] = 1'($urandom_range(0, 1));
        req_addr[k]  = $urandom;
        req_wdata[k] = $urandom;
      end
    end while (!rsp_valid[k] && lat < 30);
    checkOutput("latency", 32'(lat), 32'(1 + waits_of(k)));
    checkOutput("ready_low_in_txn", 32'(rdy_bad), 32'd0);
    checkOutput("rsp_err", 32'(rsp_err[k]), 32'(exp_e));
    if (known) checkOutput("rsp_rdata", rsp_rdata[k], exp_d);
    if (w && !exp_e) begin
      if (a == LED) mdl_led[k] = d[7:0];
      else mdl_mem[key] = d;
    end
    @(negedge clk);
    checkOutput("rsp_single_cycle", 32'(rsp_valid[k]), 32'd0);
    checkOutput("led_out", 32'(led_out[k]), 32'(mdl_led[k]));
  endtask

  // Loads with req_valid held high; response spacing must equal the throughput period
  task automatic backToBack(input int k, input logic [31:0] a, input int nrsp);
    int   times[$];
    int   t;
    logic both;
    req_valid[k] = 1'b1;
    req_write[k] = 1'b0;
    req_addr[k]  = a;
    t = 0;
    both = 1'b0;
    while (times.size() < nrsp && t < 200) begin
      @(negedge clk);
      t++;
      if (req_ready[k] && rsp_valid[k]) both = 1'b1;
      if (rsp_valid[k]) begin
        times.push_back(t);
        checkOutput("btb_rdata", rsp_rdata[k], mdl_mem[k * 1024 + int'(a[11:2])]);
      end
    end
    req_valid[k] = 1'b0;
    checkOutput("btb_count", 32'(times.size()), 32'(nrsp));
    checkOutput("btb_ready_and_valid", 32'(both), 32'd0);
    for (int i = 1; i < times.size(); i++)
      checkOutput("btb_period", 32'(times[i] - times[i-1]), 32'(2 + waits_of(k)));
    @(negedge clk);
  endtask

  initial begin
    logic        w, seen;
    logic [31:0] a;
    int          kind, n;

    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req_valid[k] = 1'b1;
      req_write[k] = 1'b0;
      req_addr[k]  = 32'h10;
      req_wdata[k] = '0;
      mdl_led[k]   = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checkOutput("reset_ready", 32'(req_ready[k]), 32'd0);
      checkOutput("reset_rsp_valid", 32'(rsp_valid[k]), 32'd0);
      checkOutput("reset_led", 32'(led_out[k]), 32'd0);
    end
    checkOutput("reset_rdata", rsp_rdata[0], 32'd0);
    checkOutput("reset_err", 32'(rsp_err[0]), 32'd0);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) req_valid[k] = 1'b0;
    #1;
    checkOutput("ready_before_first_clock", 32'(req_ready[0]), 32'd0);
    @(negedge clk);
    for (int k = 0; k < 3; k++) checkOutput("ready_after_release", 32'(req_ready[k]), 32'd1);

    $display("[TB] directed transactions, 1 wait state");
    applyStimulus(0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    applyStimulus(0, 1'b0, 32'h10, 32'h0);
    applyStimulus(0, 1'b0, 32'h12, 32'h0);
    applyStimulus(0, 1'b1, 32'h0, 32'hCAFE_0001);
    applyStimulus(0, 1'b1, 32'h2000, 32'h5555_5555);
    applyStimulus(0, 1'b0, 32'h0, 32'h0);
    applyStimulus(0, 1'b1, LED, 32'h1234_56A5);
    checkOutput("led_a5", 32'(led_out[0]), 32'h0000_00A5);
    applyStimulus(0, 1'b0, LED, 32'h0);

    $display("[TB] random transactions");
    for (int i = 0; i < 8; i++) applyStimulus(0, 1'b1, 32'(i * 4), $urandom);
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
      w = 1'($urandom_range(0, 1));
      if (kind <= 5) a = (kind == 5) ? 32'hFFC : 32'($urandom_range(0, 7) * 4);
      else if (kind == 6) a = LED;
      else if (kind == 7) a = 32'($urandom_range(0, 7) * 4 + $urandom_range(1, 3));
      else begin
        a = ($urandom | 32'h1000) & 32'hFFFF_FFFC;
        if (a == LED) a = 32'h4000;
      end
      applyStimulus(0, w, a, $urandom);
    end

    $display("[TB] latency sweep");
    applyStimulus(1, 1'b1, 32'h10, 32'hA0A0_A0A0);
    applyStimulus(1, 1'b0, 32'h10, 32'h0);
    backToBack(1, 32'h10, 4);
    applyStimulus(2, 1'b1, 32'h10, 32'h0B0B_0B0B);
    applyStimulus(2, 1'b0, 32'h10, 32'h0);
    backToBack(2, 32'h10, 4);

    $display("[TB] reset during wait");
    applyStimulus(2, 1'b1, 32'h20, 32'h1111_1111);
    req_valid[2] = 1'b1;
    req_write[2] = 1'b1;
    req_addr[2]  = 32'h20;
    req_wdata[2] = 32'h2222_2222;
    n = 0;
    while (!req_ready[2] && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    req_valid[2] = 1'b0;
    #1;
    checkOutput("midreset_ready", 32'(req_ready[2]), 32'd0);
    checkOutput("midreset_rsp_valid", 32'(rsp_valid[2]), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) mdl_led[k] = 8'h00;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid[2]) seen = 1'b1;
    end
    checkOutput("midreset_no_response", 32'(seen), 32'd0);
    applyStimulus(2, 1'b0, 32'h20, 32'h0);
    checkOutput("midreset_store_dropped", mdl_mem[2 * 1024 + 8], 32'h1111_1111);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
